// File: rtl/display_pkg.sv
// Shared sizing defaults and capture state encoding for the store display receiver.
package display_pkg;

    localparam int DEF_LINE_LENGTH = 40;
    localparam int DEF_PAGE_SIZE   = 32;
    localparam int DEF_S_TUBES     = 2;
    localparam int FRAME_CNT_W     = 8;

    typedef enum logic [1:0] {
        HUNT,
        WAIT_LS,
        SHIFT,
        COMMIT
    } cap_state_t;

    // Index width that never collapses to zero bits for single-entry dimensions.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dc_frame_ram.sv
// Dual-bank line memory: one wide synchronous write of all tubes, one registered read.
module dc_frame_ram
    import display_pkg::*;
#(
    parameter int LINE_LENGTH = DEF_LINE_LENGTH,
    parameter int PAGE_SIZE   = DEF_PAGE_SIZE,
    parameter int S_TUBES     = DEF_S_TUBES,
    parameter int LINE_BITS   = $clog2(PAGE_SIZE),
    parameter int TUBE_BITS   = idx_bits(S_TUBES)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                we,
    input  logic                                wr_bank,
    input  logic [LINE_BITS-1:0]                wr_line,
    input  logic [S_TUBES-1:0][LINE_LENGTH-1:0] wr_data,
    input  logic                                rd_en,
    input  logic                                rd_bank,
    input  logic [TUBE_BITS-1:0]                rd_tube,
    input  logic [LINE_BITS-1:0]                rd_line,
    output logic [LINE_LENGTH-1:0]              rd_data,
    output logic                                rd_valid
);

    localparam int ADDR_W = 1 + TUBE_BITS + LINE_BITS;

    logic [LINE_LENGTH-1:0] mem [2**ADDR_W];
    logic                   rd_in_range;

    assign rd_in_range = (32'(rd_tube) < S_TUBES) && (32'(rd_line) < PAGE_SIZE);

    always_ff @(posedge clk) begin
        if (we) begin
            for (int t = 0; t < S_TUBES; t++)
                mem[{wr_bank, TUBE_BITS'(t), wr_line}] <= wr_data[t];
        end
    end

    // Memory contents survive reset; only the output register is cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= rd_in_range ? mem[{rd_bank, rd_tube, rd_line}] : '0;
        end
    end

endmodule

// File: rtl/display_capture.sv
// Deserialises the serial S-tube display stream into a double-buffered frame memory.
module display_capture
    import display_pkg::*;
#(
    parameter int LINE_LENGTH = DEF_LINE_LENGTH,
    parameter int PAGE_SIZE   = DEF_PAGE_SIZE,
    parameter int S_TUBES     = DEF_S_TUBES,
    parameter int LINE_BITS   = $clog2(PAGE_SIZE),
    parameter int TUBE_BITS   = idx_bits(S_TUBES)
) (
    input  logic                   w_CLK,
    input  logic                   w_RST_N,
    input  logic                   w_DISP_FS,
    input  logic                   w_DISP_LS,
    input  logic                   w_DISP_STB,
    input  logic [S_TUBES-1:0]     DISP_DATA,
    input  logic                   w_RD_EN,
    input  logic [TUBE_BITS-1:0]   b_RD_TUBE,
    input  logic [LINE_BITS-1:0]   b_RD_LINE,
    output logic [0:LINE_LENGTH-1] b_RD_DATA,
    output logic                   w_RD_VALID,
    output logic                   w_FRAME_DONE,
    output logic [FRAME_CNT_W-1:0] b_FRAME_CNT,
    output logic                   w_SYNC_ERR
);

    localparam int BIT_W = idx_bits(LINE_LENGTH);
    localparam logic [BIT_W-1:0]     LAST_BIT  = BIT_W'(LINE_LENGTH - 1);
    localparam logic [LINE_BITS-1:0] LAST_LINE = LINE_BITS'(PAGE_SIZE - 1);

    cap_state_t                          state, state_nxt;
    logic [BIT_W-1:0]                    bit_cnt, bit_nxt;
    logic [LINE_BITS-1:0]                line_cnt, line_nxt;
    logic [S_TUBES-1:0][LINE_LENGTH-1:0] sr, sr_nxt;
    logic                                wr_bank, bank_nxt;
    logic                                err_nxt, done_nxt, commit;
    logic [FRAME_CNT_W-1:0]              cnt_nxt;
    logic [LINE_LENGTH-1:0]              rd_q;

    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        line_nxt  = line_cnt;
        sr_nxt    = sr;
        err_nxt   = w_SYNC_ERR;
        bank_nxt  = wr_bank;
        cnt_nxt   = b_FRAME_CNT;
        done_nxt  = 1'b0;
        commit    = 1'b0;
        if (w_DISP_FS) begin
            // A frame start always restarts at line 0; outside HUNT it aborts the frame.
            state_nxt = WAIT_LS;
            line_nxt  = '0;
            err_nxt   = (state != HUNT) || w_DISP_STB;
        end else begin
            case (state)
                HUNT: ;
                WAIT_LS: begin
                    if (w_DISP_LS) begin
                        state_nxt = SHIFT;
                        bit_nxt   = '0;
                    end
                    if (w_DISP_STB)
                        err_nxt = 1'b1;
                end
                SHIFT: begin
                    if (w_DISP_LS) begin
                        bit_nxt = '0;
                        err_nxt = 1'b1;
                    end else if (w_DISP_STB) begin
                        for (int t = 0; t < S_TUBES; t++)
                            sr_nxt[t][bit_cnt] = DISP_DATA[t];
                        bit_nxt = bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT)
                            state_nxt = COMMIT;
                    end
                end
                COMMIT: begin
                    commit = 1'b1;
                    if (w_DISP_STB)
                        err_nxt = 1'b1;
                    if (line_cnt == LAST_LINE) begin
                        state_nxt = HUNT;
                        line_nxt  = '0;
                        bank_nxt  = ~wr_bank;
                        done_nxt  = 1'b1;
                        cnt_nxt   = b_FRAME_CNT + 1'b1;
                    end else begin
                        state_nxt = WAIT_LS;
                        line_nxt  = line_cnt + 1'b1;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge w_CLK or negedge w_RST_N) begin
        if (!w_RST_N) begin
            state        <= HUNT;
            bit_cnt      <= '0;
            line_cnt     <= '0;
            sr           <= '0;
            wr_bank      <= 1'b0;
            w_SYNC_ERR   <= 1'b0;
            w_FRAME_DONE <= 1'b0;
            b_FRAME_CNT  <= '0;
        end else begin
            state        <= state_nxt;
            bit_cnt      <= bit_nxt;
            line_cnt     <= line_nxt;
            sr           <= sr_nxt;
            wr_bank      <= bank_nxt;
            w_SYNC_ERR   <= err_nxt;
            w_FRAME_DONE <= done_nxt;
            b_FRAME_CNT  <= cnt_nxt;
        end
    end

    // Read bank is always the one not being written, so it flips on the same edge as the swap.
    dc_frame_ram #(
        .LINE_LENGTH (LINE_LENGTH),
        .PAGE_SIZE   (PAGE_SIZE),
        .S_TUBES     (S_TUBES),
        .LINE_BITS   (LINE_BITS),
        .TUBE_BITS   (TUBE_BITS)
    ) u_ram (
        .clk      (w_CLK),
        .rst_n    (w_RST_N),
        .we       (commit),
        .wr_bank  (wr_bank),
        .wr_line  (line_cnt),
        .wr_data  (sr),
        .rd_en    (w_RD_EN),
        .rd_bank  (~wr_bank),
        .rd_tube  (b_RD_TUBE),
        .rd_line  (b_RD_LINE),
        .rd_data  (rd_q),
        .rd_valid (w_RD_VALID)
    );

    // Output bit i is the i-th digit received on the line.
    for (genvar i = 0; i < LINE_LENGTH; i++) begin : g_rd_map
        assign b_RD_DATA[i] = rd_q[i];
    end

endmodule

// File: doc/display_capture.md
Name: display_capture

Overview:
- Receiving end of the store display interface: the machine emits S-tube contents serially, one bit per tube per digit strobe, line after line.
- This block deserialises that stream into a double-buffered frame memory of S_TUBES × PAGE_SIZE lines × LINE_LENGTH bits.
- A host or scope-side reader can fetch any completed line while the next frame is being captured.
- It sits beside the machine top level on the DISP_DATA outputs and feeds the panel/monitor logic.

Parameters:
- LINE_LENGTH, 40, bits per store line (digits per displayed line).
- PAGE_SIZE, 32, lines per tube per frame.
- S_TUBES, 2, number of store tubes streamed in parallel.
- LINE_BITS, $clog2(PAGE_SIZE), line index width.
- TUBE_BITS, max(1,$clog2(S_TUBES)), tube index width.

Ports:
- w_CLK  in  1  system clock; all logic on rising edge.
- w_RST_N  in  1  asynchronous active-low reset.
- w_DISP_FS  in  1  frame-start marker, one-cycle pulse.
- w_DISP_LS  in  1  line-start marker, one-cycle pulse.
- w_DISP_STB  in  1  digit strobe; DISP_DATA is valid in this cycle.
- DISP_DATA  in  S_TUBES  one serial bit per tube.
- w_RD_EN  in  1  read request.
- b_RD_TUBE  in  TUBE_BITS  tube to read.
- b_RD_LINE  in  LINE_BITS  line to read.
- b_RD_DATA  out  [0:LINE_LENGTH-1]  read line from the completed bank.
- w_RD_VALID  out  1  b_RD_DATA valid.
- w_FRAME_DONE  out  1  one-cycle pulse on bank swap.
- b_FRAME_CNT  out  8  completed-frame counter; wraps at 255→0.
- w_SYNC_ERR  out  1  sticky framing error; cleared only by the next valid frame start.

Behaviour:
- Reset (async, w_RST_N=0):
  - state=HUNT; bit and line counters 0; write bank 0, read bank 1.
  - Frame memory is not cleared. Reset is permitted mid-line or mid-frame.
  - All outputs 0: b_RD_DATA, w_RD_VALID, w_FRAME_DONE, b_FRAME_CNT, w_SYNC_ERR.
- State machine:
  - HUNT: ignore STB and LS; FS → WAIT_LS, line=0, w_SYNC_ERR←0.
  - WAIT_LS: LS → SHIFT, bit=0; STB here → w_SYNC_ERR←1, strobe dropped.
  - SHIFT: on each STB, DISP_DATA[t] goes into shift register t at index bit (first digit → bit 0); bit++.
    - When the LINE_LENGTH-th strobe is taken, go to COMMIT.
  - COMMIT (one cycle): write all S_TUBES shift registers to the write bank at line index; line++.
    - If line was PAGE_SIZE-1: swap banks, pulse w_FRAME_DONE, b_FRAME_CNT++, go to HUNT.
    - Otherwise go to WAIT_LS.
- Framing error cases (each sets w_SYNC_ERR):
  - LS in SHIFT before LINE_LENGTH strobes: partial line discarded, line index not advanced, restart SHIFT with bit=0.
  - FS in any state other than HUNT: abort the frame, no swap; write bank contents are undefined for lines already written; go to WAIT_LS with line=0.
  - FS arriving in HUNT sets no error.
- Marker priority:
  - FS beats LS beats STB in the same cycle; the lower-priority event is dropped.
  - A dropped STB sets w_SYNC_ERR.
- Strobes in COMMIT are dropped and set w_SYNC_ERR. The machine guarantees at least one idle cycle after the last digit.
- Read port:
  - w_RD_EN samples b_RD_TUBE and b_RD_LINE against the read bank current in that cycle.
  - b_RD_DATA and w_RD_VALID are registered, 1-cycle latency. w_RD_VALID is high for exactly one cycle per request; back-to-back reads are allowed.
  - A bank swap coincident with w_RD_EN: the read returns the pre-swap bank.
  - An out-of-range tube or line index returns all zeros, with w_RD_VALID still asserted.
- No output depends combinationally on inputs.

Decomposition:
- Shared package display_pkg:
  - LINE_LENGTH, PAGE_SIZE, S_TUBES defaults.
  - The state encoding (HUNT, WAIT_LS, SHIFT, COMMIT).
  - The frame-counter width.
- One sub-module, dc_frame_ram: dual-bank memory with one synchronous write port and one registered read port.
  - Address = {bank, tube, line}.
  - Instantiated once.
  - Serialiser FSM and counters stay in the top.

Test Plan:
- Full clean frame: FS, then 32×(LS + 40 STB) with tube0 line k = k, tube1 line k = ~k (bit 0 first) → one w_FRAME_DONE, b_FRAME_CNT=1; reading tube0/line5 gives 5, tube1/line5 gives ~5; w_SYNC_ERR=0.
- Short line: in line 3, send LS after 20 STB → w_SYNC_ERR=1; resent line 3 is stored correctly, frame still completes after 32 good lines, FRAME_CNT increments.
- FS mid-frame at line 10 → no FRAME_DONE, read bank unchanged (still returns previous frame); the following clean frame completes and clears w_SYNC_ERR.
- Read during swap: w_RD_EN in the same cycle as the COMMIT of line 31 → returns old-frame data; the next cycle's read returns new data; w_RD_VALID is one cycle each.
- Async reset asserted mid-SHIFT (line 7, bit 12) → all outputs 0 immediately; STB/LS ignored until FS; the next full frame captures correctly.
- 256 clean frames → b_FRAME_CNT wraps to 0 with w_FRAME_DONE pulse count 256; FS+STB in the same cycle → strobe dropped, w_SYNC_ERR=1.
